// File: rtl/ram_controller.sv
// Arbitrates one 16-bit SRAM between instruction fetch (two reads per 32-bit word) and data load/store; data wins in IDLE.
// Idle-bus latency: fetch 2W+4, data read W+3, data write W+4 cycles; requests queue via per-client pending flags.
module ram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [15:0]        fetch_addr,
  output logic [31:0]        fetch_data,
  output logic               fetch_ready,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [15:0]        data_addr,
  input  logic [15:0]        data_wdata,
  output logic [15:0]        data_rdata,
  output logic               data_done,
  output logic               busy,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_oe,
  output logic               sram_we
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] F_LO       = 3'd1;
  localparam logic [2:0] F_HI       = 3'd2;
  localparam logic [2:0] D_RD       = 3'd3;
  localparam logic [2:0] D_WR_SETUP = 3'd4;
  localparam logic [2:0] D_WR       = 3'd5;
  localparam logic [2:0] DONE_F     = 3'd6;
  localparam logic [2:0] DONE_D     = 3'd7;
  localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        pend_f_q, pend_f_d;
  logic        pend_d_q, pend_d_d;
  logic [15:0] f_addr_q, f_addr_d;
  logic        d_we_q, d_we_d;
  logic [15:0] d_addr_q, d_addr_d;
  logic [15:0] d_wdata_q, d_wdata_d;
  logic [15:0] instr_lo_q, instr_lo_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [15:0] data_rdata_q, data_rdata_d;
  logic        last_wait;

  assign last_wait = (wait_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pend_f_d     = pend_f_q;
    pend_d_d     = pend_d_q;
    f_addr_d     = f_addr_q;
    d_we_d       = d_we_q;
    d_addr_d     = d_addr_q;
    d_wdata_d    = d_wdata_q;
    instr_lo_d   = instr_lo_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;

    // A strobe while the same client is still pending is dropped so latched operands stay intact.
    if (state_q == DONE_F) begin
      pend_f_d = 1'b0;
    end else if (fetch_req && !pend_f_q) begin
      pend_f_d = 1'b1;
      f_addr_d = fetch_addr;
    end
    if (state_q == DONE_D) begin
      pend_d_d = 1'b0;
    end else if (data_req && !pend_d_q) begin
      pend_d_d  = 1'b1;
      d_we_d    = data_we;
      d_addr_d  = data_addr;
      d_wdata_d = data_wdata;
    end

    case (state_q)
      IDLE: begin
        wait_d = 3'd0;
        if (pend_d_q)      state_d = d_we_q ? D_WR_SETUP : D_RD;
        else if (pend_f_q) state_d = F_LO;
      end
      F_LO, F_HI, D_RD, D_WR: begin
        if (last_wait) begin
          wait_d = 3'd0;
          case (state_q)
            F_LO: begin
              instr_lo_d = sram_dq_in;
              state_d    = F_HI;
            end
            F_HI: begin
              fetch_data_d = {sram_dq_in, instr_lo_q};
              state_d      = DONE_F;
            end
            D_RD: begin
              data_rdata_d = sram_dq_in;
              state_d      = DONE_D;
            end
            default: state_d = DONE_D;
          endcase
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      D_WR_SETUP: state_d = D_WR;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = 16'h0;
    sram_oe     = 1'b0;
    sram_dq_oe  = 1'b0;
    sram_we     = 1'b0;
    case (state_q)
      F_LO: begin
        sram_addr = SRAM_AW'({f_addr_q, 1'b0});
        sram_oe   = 1'b1;
      end
      F_HI: begin
        sram_addr = SRAM_AW'({f_addr_q, 1'b1});
        sram_oe   = 1'b1;
      end
      D_RD: begin
        sram_addr = SRAM_AW'(d_addr_q);
        sram_oe   = 1'b1;
      end
      D_WR_SETUP, D_WR: begin
        sram_addr   = SRAM_AW'(d_addr_q);
        sram_dq_out = d_wdata_q;
        sram_dq_oe  = 1'b1;
        sram_we     = (state_q == D_WR);
      end
      default: ;
    endcase
  end

  assign fetch_data  = fetch_data_q;
  assign data_rdata  = data_rdata_q;
  assign fetch_ready = (state_q == DONE_F);
  assign data_done   = (state_q == DONE_D);
  assign busy        = pend_f_q | pend_d_q | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= 3'd0;
      pend_f_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      f_addr_q     <= 16'h0;
      d_we_q       <= 1'b0;
      d_addr_q     <= 16'h0;
      d_wdata_q    <= 16'h0;
      instr_lo_q   <= 16'h0;
      fetch_data_q <= 32'h0;
      data_rdata_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      pend_f_q     <= pend_f_d;
      pend_d_q     <= pend_d_d;
      f_addr_q     <= f_addr_d;
      d_we_q       <= d_we_d;
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      instr_lo_q   <= instr_lo_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Directed bench: u1 runs with WAIT_CYCLES=1, u0 with WAIT_CYCLES=0, each against its own SRAM model.
module tb_ram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        f1_req, f1_rdy, d1_req, d1_we, d1_done, busy1, dqoe1, oe1, we1;
  logic [15:0] f1_addr, d1_addr, d1_wd, d1_rd, dqo1, dqi1;
  logic [31:0] f1_data;
  logic [16:0] a1;
  logic        f0_req, f0_rdy, d0_req, d0_we, d0_done, busy0, dqoe0, oe0, we0;
  logic [15:0] f0_addr, d0_addr, d0_wd, d0_rd, dqo0, dqi0;
  logic [31:0] f0_data;
  logic [16:0] a0;

  logic [15:0] mem1 [0:131071];
  logic [15:0] mem0 [0:131071];
  assign dqi1 = oe1 ? mem1[a1] : 16'h0;
  assign dqi0 = oe0 ? mem0[a0] : 16'h0;
  always @(posedge clk) if (we1) mem1[a1] <= dqo1;
  always @(posedge clk) if (we0) mem0[a0] <= dqo0;

  ram_controller #(.WAIT_CYCLES(1), .SRAM_AW(17)) u1 (
    .clk(clk), .rst(rst), .fetch_req(f1_req), .fetch_addr(f1_addr), .fetch_data(f1_data),
    .fetch_ready(f1_rdy), .data_req(d1_req), .data_we(d1_we), .data_addr(d1_addr),
    .data_wdata(d1_wd), .data_rdata(d1_rd), .data_done(d1_done), .busy(busy1),
    .sram_addr(a1), .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(dqoe1),
    .sram_oe(oe1), .sram_we(we1));

  ram_controller #(.WAIT_CYCLES(0), .SRAM_AW(17)) u0 (
    .clk(clk), .rst(rst), .fetch_req(f0_req), .fetch_addr(f0_addr), .fetch_data(f0_data),
    .fetch_ready(f0_rdy), .data_req(d0_req), .data_we(d0_we), .data_addr(d0_addr),
    .data_wdata(d0_wd), .data_rdata(d0_rd), .data_done(d0_done), .busy(busy0),
    .sram_addr(a0), .sram_dq_out(dqo0), .sram_dq_in(dqi0), .sram_dq_oe(dqoe0),
    .sram_oe(oe0), .sram_we(we0));

  int checks = 0;
  int failures = 0;
  int rc, rn, dc, wn, wf;
  logic stable;
  logic [15:0] bb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe u0 once and record the first cycle of each completion pulse (0 = never seen).
  task automatic run0(input logic f, input logic d, input logic we, input logic [15:0] addr,
                      input logic [15:0] wd, output int rcy, output int dcy);
    rcy = 0;
    dcy = 0;
    @(negedge clk);
    f0_req = f; f0_addr = addr; d0_req = d; d0_we = we; d0_addr = addr; d0_wd = wd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin f0_req = 1'b0; d0_req = 1'b0; end
      if (f0_rdy && rcy == 0) rcy = k;
      if (d0_done && dcy == 0) dcy = k;
    end
  endtask

  initial begin
    rst = 1'b1;
    f1_req = 0; f1_addr = 0; d1_req = 0; d1_we = 0; d1_addr = 0; d1_wd = 0;
    f0_req = 0; f0_addr = 0; d0_req = 0; d0_we = 0; d0_addr = 0; d0_wd = 0;
    mem1[17'h00020] = 16'h1234; mem1[17'h00021] = 16'hABCD; mem1[17'h00005] = 16'h5555;
    mem1[17'h1FFFE] = 16'h1111; mem1[17'h1FFFF] = 16'h2222;
    mem0[17'h00020] = 16'h1234; mem0[17'h00021] = 16'hABCD; mem0[17'h00005] = 16'h5555;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ctrl", 32'({busy1, f1_rdy, d1_done, oe1, we1, dqoe1}), 32'h0);
    chk("rst_addr", 32'(a1), 32'h0);
    chk("rst_dq_out", 32'(dqo1), 32'h0);
    chk("rst_fetch_data", f1_data, 32'h0);
    chk("rst_rdata", 32'(d1_rd), 32'h0);

    // Basic fetch, PC changed right after the strobe
    @(negedge clk);
    f1_req = 1'b1; f1_addr = 16'h0010;
    chk("t1_busy_c0", 32'(busy1), 32'h0);
    bb = '0; rc = 0; rn = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin f1_req = 1'b0; f1_addr = 16'h7777; end
      bb[k-1] = busy1;
      if (f1_rdy) begin rn++; if (rc == 0) rc = k; end
      if (k == 2) chk("t1_addr_lo", 32'(a1), 32'h20);
      if (k == 4) chk("t1_addr_hi", 32'(a1), 32'h21);
      if (k == 6) chk("t1_data", f1_data, 32'hABCD1234);
    end
    chk("t1_ready_cycle", rc, 6);
    chk("t1_ready_count", rn, 1);
    chk("t1_busy", 32'(bb), 32'h3F);

    // Simultaneous fetch and data read: data first, busy continuous
    @(negedge clk);
    f1_req = 1'b1; f1_addr = 16'h0010; d1_req = 1'b1; d1_we = 1'b0; d1_addr = 16'h0005;
    bb = '0; rc = 0; dc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin f1_req = 1'b0; d1_req = 1'b0; end
      bb[k-1] = busy1;
      if (d1_done && dc == 0) begin dc = k; chk("t2_rdata", 32'(d1_rd), 32'h5555); end
      if (f1_rdy && rc == 0) begin rc = k; chk("t2_fdata", f1_data, 32'hABCD1234); end
    end
    chk("t2_done_cycle", dc, 4);
    chk("t2_ready_cycle", rc, 10);
    chk("t2_busy", 32'(bb), 32'h3FF);

    // Write 0xBEEF to 0x0007
    @(negedge clk);
    d1_req = 1'b1; d1_we = 1'b1; d1_addr = 16'h0007; d1_wd = 16'hBEEF;
    wn = 0; wf = 0; dc = 0; stable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) d1_req = 1'b0;
      if (we1) begin wn++; if (wf == 0) wf = k; end
      if (k >= 2 && k <= 4 && !(dqoe1 && a1 == 17'h7 && dqo1 == 16'hBEEF)) stable = 1'b0;
      if (k == 2) chk("t3_setup_we", 32'(we1), 32'h0);
      if (d1_done && dc == 0) begin dc = k; chk("t3_done_ctrl", 32'({we1, dqoe1}), 32'h0); end
    end
    chk("t3_we_count", wn, 2);
    chk("t3_we_first", wf, 3);
    chk("t3_stable", 32'(stable), 32'h1);
    chk("t3_done_cycle", dc, 5);
    chk("t3_rdata_kept", 32'(d1_rd), 32'h5555);
    chk("t3_mem", 32'(mem1[17'h7]), 32'hBEEF);

    @(negedge clk);
    d1_req = 1'b1; d1_we = 1'b0; d1_addr = 16'h0007;
    dc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) d1_req = 1'b0;
      if (d1_done && dc == 0) dc = k;
    end
    chk("t3_rb_cycle", dc, 4);
    chk("t3_rb_data", 32'(d1_rd), 32'hBEEF);

    // Reset during the second F_HI cycle
    @(negedge clk);
    f1_req = 1'b1; f1_addr = 16'h0010;
    rn = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) f1_req = 1'b0;
      if (f1_rdy) rn++;
      if (k == 5) begin chk("t4_in_fhi", 32'(a1), 32'h21); rst = 1'b1; end
      if (k == 6) begin
        rst = 1'b0;
        chk("t4_ctrl_zero", 32'({busy1, f1_rdy, d1_done, oe1, we1, dqoe1}), 32'h0);
        chk("t4_addr_zero", 32'(a1), 32'h0);
        chk("t4_data_zero", f1_data, 32'h0);
        chk("t4_rdata_zero", 32'(d1_rd), 32'h0);
      end
    end
    chk("t4_no_ready", rn, 0);
    @(negedge clk);
    f1_req = 1'b1; f1_addr = 16'h0010;
    rc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) f1_req = 1'b0;
      if (f1_rdy && rc == 0) rc = k;
    end
    chk("t4_refetch_cycle", rc, 6);
    chk("t4_refetch_data", f1_data, 32'hABCD1234);

    // Wrap-around address plus a repeated strobe while pending
    @(negedge clk);
    f1_req = 1'b1; f1_addr = 16'hFFFF;
    rc = 0; rn = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) f1_req = 1'b0;
      if (k == 3) begin f1_req = 1'b1; f1_addr = 16'h0010; end
      if (k == 4) f1_req = 1'b0;
      if (f1_rdy) begin rn++; if (rc == 0) rc = k; end
      if (k == 2) chk("t5_addr_lo", 32'(a1), 32'h1FFFE);
      if (k == 4) chk("t5_addr_hi", 32'(a1), 32'h1FFFF);
      if (k == 6) chk("t5_data", f1_data, 32'h22221111);
      if (k == 7) chk("t5_busy_after", 32'(busy1), 32'h0);
    end
    chk("t5_ready_cycle", rc, 6);
    chk("t5_ready_count", rn, 1);

    // Zero wait states
    run0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, rc, dc);
    chk("t6_fetch_cycle", rc, 4);
    chk("t6_fetch_data", f0_data, 32'hABCD1234);
    run0(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, rc, dc);
    chk("t6_read_cycle", dc, 3);
    chk("t6_read_data", 32'(d0_rd), 32'h5555);
    run0(1'b0, 1'b1, 1'b1, 16'h0007, 16'hBEEF, rc, dc);
    chk("t6_write_cycle", dc, 4);
    chk("t6_write_mem", 32'(mem0[17'h7]), 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_controller.md
Name: ram_controller

Overview:
- Sits directly upstream of the fetch stage. Owns the external 16-bit SRAM bus and arbitrates between two clients: the instruction fetch port and the execute-stage data (load/store) port.
- Builds each 32-bit instruction from two consecutive 16-bit SRAM reads.
- Gives both clients a busy indication and a completion strobe.

Parameters:
WAIT_CYCLES, 1, extra wait cycles per SRAM access; each read access lasts WAIT_CYCLES+1 cycles (range 0..7).
SRAM_AW, 17, SRAM word-address width; instruction address maps to {fetch_addr,0}/{fetch_addr,1}.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
fetch_req  in  1  single-cycle strobe: fetch instruction at fetch_addr
fetch_addr  in  16  instruction address (PC), sampled with fetch_req
fetch_data  out  32  assembled instruction; holds until next fetch completes
fetch_ready  out  1  one-cycle pulse: fetch_data valid
data_req  in  1  single-cycle strobe: data access
data_we  in  1  1=write, 0=read; sampled with data_req
data_addr  in  16  data word address, sampled with data_req; SRAM addr = {1'b0,data_addr} zero-extended to SRAM_AW
data_wdata  in  16  write data, sampled with data_req
data_rdata  out  16  read result; holds until next data read completes
data_done  out  1  one-cycle pulse: data access finished
busy  out  1  high while any request is pending or in service
sram_addr  out  SRAM_AW  SRAM address
sram_dq_out  out  16  SRAM write data
sram_dq_in  in  16  SRAM read data
sram_dq_oe  out  1  drive dq bus
sram_oe  out  1  SRAM output enable, active-high
sram_we  out  1  SRAM write enable, active-high

Behaviour:
- Reset: state IDLE, both pending flags clear, wait counter 0. All outputs 0: fetch_data, data_rdata, strobes, busy, SRAM controls, sram_addr, sram_dq_out.
- Request capture: a strobe high at a rising edge sets that client's pending flag and latches its address/we/wdata. Capture happens in any state.
  - A strobe is ignored while the same client's flag is already set; the latched values are not overwritten.
  - The flag clears on the edge where that client's completion strobe is asserted.
- busy is combinational: pending_fetch | pending_data | (state != IDLE). It rises in the cycle after a strobe.
- States: IDLE, F_LO, F_HI, D_RD, D_WR_SETUP, D_WR, DONE_F, DONE_D.
- IDLE arbitration: data has priority. pending_data selects D_RD or D_WR_SETUP; else pending_fetch selects F_LO; else stay in IDLE.
- Read access states (F_LO, F_HI, D_RD):
  - Drive sram_addr, sram_oe=1, sram_dq_oe=0.
  - Stay WAIT_CYCLES+1 cycles, counted by a wait counter.
  - sram_dq_in is sampled at the last edge.
- F_LO: address {addr,0}; captures instr[15:0], then goes to F_HI.
- F_HI: address {addr,1}; captures instr[31:16], then goes to DONE_F.
- D_RD: captures data_rdata, then goes to DONE_D.
- Write:
  - D_WR_SETUP: one cycle; addr and dq driven, sram_dq_oe=1, sram_we=0.
  - D_WR: sram_we=1 for WAIT_CYCLES+1 cycles, addr and dq held.
  - Then DONE_D with sram_dq_oe=0 and sram_we=0. data_rdata is unchanged.
- DONE_F: fetch_ready=1 for exactly one cycle, with fetch_data updated on the entry edge. DONE_D does the same with data_done. Both return to IDLE.
- No back-to-back bypass: each transaction passes through IDLE. Arbitration happens only in IDLE; an in-flight fetch is never preempted.
- Latency, strobe in cycle 0, WAIT_CYCLES=W, bus idle:
  - fetch_ready in cycle 2W+4.
  - data read done in cycle W+3.
  - data write done in cycle W+4.
- Simultaneous fetch_req and data_req: data is served first, then fetch; busy stays high continuously.
- A fetch arriving while a data access is in service is queued and served after the following IDLE cycle.
- fetch_addr changing after the strobe has no effect on the transaction in flight.
- rst mid-transaction: next cycle is IDLE with all flags and outputs at reset values. No completion pulse; sram_we drops immediately.
- Wrap-around: fetch_addr=16'hFFFF yields SRAM addresses 17'h1FFFE and 17'h1FFFF; no overflow into other bits.

Test Plan:
- W=1: mem[0x00020]=0x1234, mem[0x00021]=0xABCD; fetch_req with fetch_addr=0x0010 in cycle 0 -> fetch_ready pulse in cycle 6, fetch_data=0xABCD1234, busy high cycles 1-6.
- Same-cycle fetch_req (addr 0x0010) and data_req read of addr 0x0005 (mem=0x5555) -> data_done first with data_rdata=0x5555, then fetch_ready with 0xABCD1234; busy never drops between them.
- Data write addr 0x0007 data 0xBEEF, then read back -> sram_we high exactly W+1 cycles after a 1-cycle setup with stable addr/dq; readback data_rdata=0xBEEF.
- rst asserted in the second F_HI cycle -> no fetch_ready, all outputs 0 next cycle, subsequent fetch completes normally.
- fetch_addr=0xFFFF -> sram_addr sequence 0x1FFFE then 0x1FFFF; repeat the fetch_req while pending -> single fetch_ready only.
- WAIT_CYCLES=0 -> fetch_ready cycle 4, read done cycle 3, write done cycle 4.
